sevenseg_frame_reader: RTL
==========================

Name: sevenseg_frame_reader

Overview:
- Reads a multiplexed, scanned seven-segment display bus and recovers the displayed hex value. This is the reading end of the segment encoding the team's `sevensegment` decoder drives.
- Samples segment lines and digit-enable (anode) lines every clock and filters out scan transitions with a stability counter.
- Decodes each stable segment pattern back to a nibble and assembles a full multi-digit frame.
- Sits on the observation side of display drivers: self-checking benches and loopback test logic.

Parameters:
- NDIG, 4: number of scanned digits; 2..8.
- STABLE, 4: consecutive clock edges an {an,seg} value must be held before it is captured; 2..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- seg  input  7  segment lines, active-high; seg[0]=a, seg[1]=b, … seg[6]=g.
- an  input  NDIG  digit enables, active-high, one-hot when a digit is driven; an[0] = least-significant digit.
- value  output  4*NDIG  last complete frame; digit i in value[4i+3:4i].
- blank  output  NDIG  per-digit flag from last frame: the digit was dark (seg==0).
- invalid  output  NDIG  per-digit flag from last frame: the pattern was not in the decode table.
- frame_valid  output  1  one-cycle pulse when value/blank/invalid update.
- frame_err  output  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset (rst=1 at an edge) clears everything:
  - value, blank, invalid, frame_valid and frame_err go to 0.
  - The sample register, stability counter, shadow registers and FSM are cleared; the FSM returns to IDLE.
  - Reset mid-frame discards all partial data; no pulse is generated.
- Stability filter:
  - s_q is the registered {an,seg}.
  - If the input equals s_q, cnt increments, saturating at STABLE. Otherwise cnt is cleared to 1 and s_q is loaded.
  - A capture event fires exactly once per stable period, at the edge where cnt becomes STABLE. That edge is the STABLE-th consecutive edge seeing the same value.
  - An input held fewer than STABLE edges produces no capture.
- Capture classification:
  - an==0: ignored (inter-digit blanking).
  - an with more than one bit set: abort.
  - an one-hot at index i: digit capture of index i.
- Decode table (hex seg → nibble):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F
  - seg==00 → nibble 0, blank bit set.
  - Any other pattern → nibble 0, invalid bit set.
- Frame FSM:
  - States are IDLE and COLLECT, plus an expected-digit index exp.
  - IDLE: a digit-0 capture stores shadow[0], sets exp=1 and moves to COLLECT. Any other digit capture is ignored.
  - COLLECT, digit 0 captured: the frame restarts. Shadow is cleared, shadow[0] is stored, exp=1.
  - COLLECT, digit == exp: shadow[exp] is stored and exp increments.
  - COLLECT, any other digit: abort.
  - When exp==NDIG-1 is captured:
    - At that same edge, value/blank/invalid load from the shadow registers plus the current digit.
    - frame_valid is 1 for the following cycle only.
    - The FSM returns to IDLE.
- Abort: frame_err is 1 for one cycle after the aborting edge. Shadow is cleared and the FSM goes to IDLE. value/blank/invalid keep their previous frame.
  - A multi-hot abort also occurs in IDLE.
- frame_valid and frame_err are never high together.
- Outputs are fully registered; there is no combinational path from input to output.

Test Plan:
- Scan 0x1A3F with STABLE=4, NDIG=4: an=0001/seg=71, an=0010/seg=4F, an=0100/seg=77, an=1000/seg=06, each held 6 cycles with 2 cycles of an=0 between.
  - Required: value=16'h1A3F, blank=0, invalid=0, one frame_valid pulse on the cycle after the 4th edge of digit 3.
- Glitch rejection: same scan, but digit 2 is preceded by seg=7F held 3 cycles.
  - Required: no capture of 8; value=16'h1A3F.
- Out-of-order: digit 0 (3F), then digit 2 (06).
  - Required: frame_err pulse, no frame_valid, value unchanged from prior frame.
- Invalid and blank: digit 1 seg=01, digit 3 seg=00, others 3F.
  - Required: value=16'h0000, invalid=4'b0010, blank=4'b1000, frame_valid pulse.
- Multi-hot: an=0011, seg=3F held 5 cycles in IDLE.
  - Required: exactly one frame_err pulse.
  - Then a valid scan of 0x2222 gives value=16'h2222.
- Reset mid-frame: after digits 0–1 of 0x1234, assert rst for 1 cycle, then scan digits 2–3 only.
  - Required: all outputs 0, no pulses.
  - A following full scan of 0x1234 gives value=16'h1234.

Source files
------------

// File: rtl/sevenseg_frame_reader.sv
// Recovers the hex value shown on a scanned 7-segment bus; each {an,seg} must hold STABLE edges to count.
// Outputs registered: frame result appears the cycle after the last digit's capture edge; no backpressure.
module sevenseg_frame_reader #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           seg,
  input  logic [NDIG-1:0]      an,
  output logic [4*NDIG-1:0]    value,
  output logic [NDIG-1:0]      blank,
  output logic [NDIG-1:0]      invalid,
  output logic                 frame_valid,
  output logic                 frame_err
);

  localparam int SW = NDIG + 7;
  localparam int EW = $clog2(NDIG);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       s_q, s_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [EW-1:0]       exp_q, exp_d;
  logic [4*NDIG-1:0]   nib_q, nib_d;
  logic [NDIG-1:0]     blk_q, blk_d;
  logic [NDIG-1:0]     inv_q, inv_d;
  logic [4*NDIG-1:0]   value_q, value_d;
  logic [NDIG-1:0]     blank_q, blank_d;
  logic [NDIG-1:0]     invalid_q, invalid_d;
  logic                fv_q, fv_d;
  logic                fe_q, fe_d;

  logic [SW-1:0]       cur;
  logic                capture;
  logic                multi;
  logic [EW-1:0]       dig_idx;
  logic [5:0]          dec;

  // Returns {invalid, blank, nibble}.
  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: return 6'h00;
      7'h06: return 6'h01;
      7'h5B: return 6'h02;
      7'h4F: return 6'h03;
      7'h66: return 6'h04;
      7'h6D: return 6'h05;
      7'h7D: return 6'h06;
      7'h07: return 6'h07;
      7'h7F: return 6'h08;
      7'h6F: return 6'h09;
      7'h77: return 6'h0A;
      7'h7C: return 6'h0B;
      7'h39: return 6'h0C;
      7'h5E: return 6'h0D;
      7'h79: return 6'h0E;
      7'h71: return 6'h0F;
      7'h00: return 6'b010000;
      default: return 6'b100000;
    endcase
  endfunction

  always_comb begin
    cur     = {an, seg};
    capture = (cur == s_q) && (cnt_q == 8'(STABLE - 1));
    multi   = (an & (an - NDIG'(1))) != '0;
    dec     = decode(seg);
    dig_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (an[i]) dig_idx = EW'(i);
    end
  end

  always_comb begin
    s_d       = s_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    exp_d     = exp_q;
    nib_d     = nib_q;
    blk_d     = blk_q;
    inv_d     = inv_q;
    value_d   = value_q;
    blank_d   = blank_q;
    invalid_d = invalid_q;
    fv_d      = 1'b0;
    fe_d      = 1'b0;

    if (cur == s_q) begin
      if (cnt_q != 8'(STABLE)) cnt_d = cnt_q + 8'd1;
    end else begin
      s_d   = cur;
      cnt_d = 8'd1;
    end

    // an==0 captures are inter-digit blanking and fall through untouched.
    if (capture && (an != '0)) begin
      if (multi) begin
        fe_d    = 1'b1;
        nib_d   = '0;
        blk_d   = '0;
        inv_d   = '0;
        exp_d   = '0;
        state_d = IDLE;
      end else if (dig_idx == '0) begin
        nib_d        = '0;
        blk_d        = '0;
        inv_d        = '0;
        nib_d[3:0]   = dec[3:0];
        blk_d[0]     = dec[4];
        inv_d[0]     = dec[5];
        exp_d        = EW'(1);
        state_d      = COLLECT;
      end else if (state_q == COLLECT && dig_idx == exp_q) begin
        nib_d[4*dig_idx +: 4] = dec[3:0];
        blk_d[dig_idx]        = dec[4];
        inv_d[dig_idx]        = dec[5];
        if (exp_q == EW'(NDIG - 1)) begin
          value_d   = nib_d;
          blank_d   = blk_d;
          invalid_d = inv_d;
          fv_d      = 1'b1;
          nib_d     = '0;
          blk_d     = '0;
          inv_d     = '0;
          exp_d     = '0;
          state_d   = IDLE;
        end else begin
          exp_d = exp_q + EW'(1);
        end
      end else if (state_q == COLLECT) begin
        fe_d    = 1'b1;
        nib_d   = '0;
        blk_d   = '0;
        inv_d   = '0;
        exp_d   = '0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      nib_q     <= '0;
      blk_q     <= '0;
      inv_q     <= '0;
      value_q   <= '0;
      blank_q   <= '0;
      invalid_q <= '0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      nib_q     <= nib_d;
      blk_q     <= blk_d;
      inv_q     <= inv_d;
      value_q   <= value_d;
      blank_q   <= blank_d;
      invalid_q <= invalid_d;
      fv_q      <= fv_d;
      fe_q      <= fe_d;
    end
  end

  assign value       = value_q;
  assign blank       = blank_q;
  assign invalid     = invalid_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;

endmodule
